hpet_multi: RTL and testbench

//  Multi-channel APB high-precision event timer; successor to the single-comparator HPET.
//  One shared free-running counter feeds NCH independent comparators, each one-shot or periodic.
//  Per-channel W1C status, counter-overflow flag, one combined interrupt plus per-channel lines to the interrupt controller.

---
 rtl/hpet_pkg.sv | 45 ++++
 rtl/hpet_channel.sv | 62 ++++++
 rtl/hpet_multi.sv | 166 ++++++++++++++++
 tb/tb_hpet_multi.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpet_pkg.sv
// Shared definitions for the multi-channel HPET: register offsets, channel
// stride, control/status bit positions, compare reset value and decode helpers.
package hpet_pkg;

  localparam logic [7:0] ADDR_GCFG = 8'h00;
  localparam logic [7:0] ADDR_CNT  = 8'h04;
  localparam logic [7:0] ADDR_STS  = 8'h08;
  localparam logic [7:0] ADDR_PSC  = 8'h0C;

  // Channel i occupies CH_STRIDE*(i+1) .. +0xF
  localparam logic [7:0] CH_STRIDE   = 8'h10;
  localparam logic [3:0] CH_OFF_CCFG = 4'h0;
  localparam logic [3:0] CH_OFF_CMP  = 4'h4;
  localparam logic [3:0] CH_OFF_STP  = 4'h8;

  localparam int unsigned GCFG_START_BIT    = 0;
  localparam int unsigned GCFG_OVF_IE_BIT   = 1;
  localparam int unsigned CCFG_INT_EN_BIT   = 0;
  localparam int unsigned CCFG_PERIODIC_BIT = 1;

  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    CH_REG_CCFG,
    CH_REG_CMP,
    CH_REG_STP,
    CH_REG_NONE
  } ch_reg_e;

  // Register within a channel window
  function automatic ch_reg_e ch_reg_decode(input logic [3:0] off);
    case (off)
      CH_OFF_CCFG: return CH_REG_CCFG;
      CH_OFF_CMP:  return CH_REG_CMP;
      CH_OFF_STP:  return CH_REG_STP;
      default:     return CH_REG_NONE;
    endcase
  endfunction

  // True when a word address falls inside channel idx's window
  function automatic logic ch_sel(input logic [7:0] addr, input int unsigned idx);
    return (32'(addr) / 32'(CH_STRIDE)) == (idx + 32'd1);
  endfunction

endpackage

// File: rtl/hpet_channel.sv
// One HPET comparator channel: CCFG, compare, step, match detect, periodic
// reload and sticky W1C status bit.
// Ports: clk/rst_n; tick and count from the shared counter; *_we write strobes
// (already gated by the top); sts_clr W1C clear; wdata write payload;
// periodic/int_en/cmp/step/sts register state for readback and interrupts.
module hpet_channel
  import hpet_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [CNT_W-1:0] count,
  input  logic             ccfg_we,
  input  logic             cmp_we,
  input  logic             stp_we,
  input  logic             sts_clr,
  input  logic [CNT_W-1:0] wdata,
  output logic             periodic,
  output logic             int_en,
  output logic [CNT_W-1:0] cmp,
  output logic [CNT_W-1:0] step,
  output logic             sts
);

  logic match_c;

  // Compared against the pre-increment count of this tick
  assign match_c = tick && (count == cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      periodic <= 1'b0;
      int_en   <= 1'b0;
      cmp      <= CNT_W'(CMP_RST);
      step     <= '0;
      sts      <= 1'b0;
    end else begin
      if (ccfg_we) begin
        periodic <= wdata[CCFG_PERIODIC_BIT];
        int_en   <= wdata[CCFG_INT_EN_BIT];
      end
      // cmp_we only arrives while stopped, so it never collides with a reload
      if (cmp_we) begin
        cmp <= wdata;
      end else if (match_c && periodic) begin
        cmp <= cmp + step;
      end
      if (stp_we) begin
        step <= wdata;
      end
      // A match in the same cycle as a clear keeps the bit set
      if (match_c) begin
        sts <= 1'b1;
      end else if (sts_clr) begin
        sts <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hpet_multi.sv
// Multi-channel APB high-precision event timer. One free-running counter feeds
// NCH comparator channels (one-shot or periodic), with W1C status, counter
// overflow flag, per-channel interrupts and a combined interrupt.
// Optional feature: define HPET_PRESCALER_EN to add the PSC tick prescaler.
// Ports: apb_pclk/apb_prstn clock and async active-low reset; apb_psel,
// apb_paddr, apb_pwrite, apb_penable, apb_pwdata APB request; apb_prdata
// combinational read data; int_vec per-channel interrupts; int_o combined.
module hpet_multi
  import hpet_pkg::*;
#(
  parameter int unsigned NCH   = 3,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PSC_W = 8
) (
  input  logic           apb_pclk,
  input  logic           apb_prstn,
  input  logic           apb_psel,
  input  logic [7:0]     apb_paddr,
  input  logic           apb_pwrite,
  input  logic           apb_penable,
  input  logic [31:0]    apb_pwdata,
  output logic [31:0]    apb_prdata,
  output logic [NCH-1:0] int_vec,
  output logic           int_o
);

  if (NCH < 1 || NCH > 8 || CNT_W < 8 || CNT_W > 32 || PSC_W < 1 || PSC_W > 32) begin : g_param_check
    $error("hpet_multi: parameter out of range");
  end

  logic [7:0]       addr_w;
  logic             wr, rd;
  logic             wr_gcfg, wr_cnt, wr_sts, wr_psc;
  logic             start, ovf_int_en, sts_ovf;
  logic [CNT_W-1:0] count;
  logic             tick;

  logic [NCH-1:0]   ch_sts, ch_int_en, ch_periodic;
  logic [CNT_W-1:0] ch_cmp [NCH];
  logic [CNT_W-1:0] ch_stp [NCH];

  assign addr_w  = {apb_paddr[7:2], 2'b00};
  assign wr      = apb_psel && apb_penable && apb_pwrite;
  assign rd      = apb_psel && !apb_pwrite;
  assign wr_gcfg = wr && (addr_w == ADDR_GCFG);
  assign wr_cnt  = wr && (addr_w == ADDR_CNT);
  assign wr_sts  = wr && (addr_w == ADDR_STS);
  assign wr_psc  = wr && (addr_w == ADDR_PSC);

`ifdef HPET_PRESCALER_EN
  logic [PSC_W-1:0] psc, div;

  // div runs 0..psc and restarts from 0 whenever the timer is stopped
  assign tick = start && (div == psc);

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      psc <= '0;
      div <= '0;
    end else begin
      if (wr_psc) begin
        psc <= apb_pwdata[PSC_W-1:0];
      end
      // >= also recovers if PSC is lowered below the running div value
      if (!start || (div >= psc)) begin
        div <= '0;
      end else begin
        div <= div + PSC_W'(1);
      end
    end
  end
`else
  logic unused_psc;
  assign unused_psc = wr_psc;
  assign tick       = start;
`endif

  // Global control, shared counter and overflow status
  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      start      <= 1'b0;
      ovf_int_en <= 1'b0;
      count      <= '0;
      sts_ovf    <= 1'b0;
    end else begin
      if (wr_gcfg) begin
        start      <= apb_pwdata[GCFG_START_BIT];
        ovf_int_en <= apb_pwdata[GCFG_OVF_IE_BIT];
      end
      // CNT writes while running are dropped; no tick can occur while stopped
      if (wr_cnt && !start) begin
        count <= apb_pwdata[CNT_W-1:0];
      end else if (tick) begin
        count <= count + CNT_W'(1);
      end
      if (tick && (count == {CNT_W{1'b1}})) begin
        sts_ovf <= 1'b1;
      end else if (wr_sts && apb_pwdata[NCH]) begin
        sts_ovf <= 1'b0;
      end
    end
  end

  // Comparator channels
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic    hit;
    ch_reg_e reg_sel;

    assign hit     = wr && ch_sel(addr_w, i);
    assign reg_sel = ch_reg_decode(addr_w[3:0]);

    hpet_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (apb_pclk),
      .rst_n    (apb_prstn),
      .tick     (tick),
      .count    (count),
      .ccfg_we  (hit && (reg_sel == CH_REG_CCFG)),
      .cmp_we   (hit && (reg_sel == CH_REG_CMP) && !start),
      .stp_we   (hit && (reg_sel == CH_REG_STP) && !start),
      .sts_clr  (wr_sts && apb_pwdata[i]),
      .wdata    (apb_pwdata[CNT_W-1:0]),
      .periodic (ch_periodic[i]),
      .int_en   (ch_int_en[i]),
      .cmp      (ch_cmp[i]),
      .step     (ch_stp[i]),
      .sts      (ch_sts[i])
    );
  end

  // Read mux, zero-extended to 32 bits
  always_comb begin
    apb_prdata = '0;
    if (rd) begin
      case (addr_w)
        ADDR_GCFG: apb_prdata = 32'({ovf_int_en, start});
        ADDR_CNT:  apb_prdata = 32'(count);
        ADDR_STS:  apb_prdata = 32'({sts_ovf, ch_sts});
`ifdef HPET_PRESCALER_EN
        ADDR_PSC:  apb_prdata = 32'(psc);
`endif
        default: begin
          for (int unsigned i = 0; i < NCH; i++) begin
            if (ch_sel(addr_w, i)) begin
              case (ch_reg_decode(addr_w[3:0]))
                CH_REG_CCFG: apb_prdata = 32'({ch_periodic[i], ch_int_en[i]});
                CH_REG_CMP:  apb_prdata = 32'(ch_cmp[i]);
                CH_REG_STP:  apb_prdata = 32'(ch_stp[i]);
                default:     apb_prdata = '0;
              endcase
            end
          end
        end
      endcase
    end
  end

  // Registered status gated by the enables
  assign int_vec = ch_sts & ch_int_en;
  assign int_o   = (|int_vec) || (sts_ovf && ovf_int_en);

  logic unused_bits;
  assign unused_bits = ^{apb_paddr[1:0], apb_pwdata};

endmodule

// File: tb/tb_hpet_multi.sv
// Self-checking bench for hpet_multi: APB tasks, per-feature test tasks and a
// count-based reference model (ticks counted from the start/stop write edges).
module tb_hpet_multi;

  localparam int unsigned NCH   = 3;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned PSC_W = 8;

  logic           apb_pclk    = 1'b0;
  logic           apb_prstn   = 1'b0;
  logic           apb_psel    = 1'b0;
  logic [7:0]     apb_paddr   = 8'h00;
  logic           apb_pwrite  = 1'b0;
  logic           apb_penable = 1'b0;
  logic [31:0]    apb_pwdata  = 32'h0;
  logic [31:0]    apb_prdata;
  logic [NCH-1:0] int_vec;
  logic           int_o;

  int checks = 0;
  int errors = 0;

  hpet_multi #(.NCH(NCH), .CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
    .apb_pclk    (apb_pclk),
    .apb_prstn   (apb_prstn),
    .apb_psel    (apb_psel),
    .apb_paddr   (apb_paddr),
    .apb_pwrite  (apb_pwrite),
    .apb_penable (apb_penable),
    .apb_pwdata  (apb_pwdata),
    .apb_prdata  (apb_prdata),
    .int_vec     (int_vec),
    .int_o       (int_o)
  );

  always #5 apb_pclk = ~apb_pclk;

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ch_addr(input int ch, input int off);
    return 8'(16 * (ch + 1) + off);
  endfunction

  // Write strobe lands on the posedge just before the task returns (at a negedge)
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge apb_pclk);
    apb_psel = 1'b1; apb_pwrite = 1'b1; apb_penable = 1'b0; apb_paddr = a; apb_pwdata = d;
    @(negedge apb_pclk);
    apb_penable = 1'b1;
    @(negedge apb_pclk);
    apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge apb_pclk);
    apb_psel = 1'b1; apb_pwrite = 1'b0; apb_penable = 1'b0; apb_paddr = a;
    @(negedge apb_pclk);
    apb_penable = 1'b1;
    #1 d = apb_prdata;
    apb_psel = 1'b0; apb_penable = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge apb_pclk);
    apb_prstn = 1'b0; apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
    @(negedge apb_pclk);
    @(negedge apb_pclk);
    apb_prstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL reset_int_o got %b exp 0", int_o); end
    checks++; if (int_vec !== '0) begin errors++; $display("FAIL reset_int_vec got %b exp 0", int_vec); end
    apb_read(8'h00, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_gcfg got %h exp 0", d); end
    apb_read(8'h04, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", d); end
    apb_read(8'h08, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_sts got %h exp 0", d); end
    apb_read(8'h0C, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_psc got %h exp 0", d); end
    for (int ch = 0; ch < int'(NCH); ch++) begin
      apb_read(ch_addr(ch, 0), d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ccfg%0d got %h exp 0", ch, d); end
      apb_read(ch_addr(ch, 4), d); checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp%0d got %h exp ffffffff", ch, d); end
      apb_read(ch_addr(ch, 8), d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_stp%0d got %h exp 0", ch, d); end
    end
  endtask

  // Random register writes while stopped, plus unmapped addresses
  task automatic test_regs();
    logic [31:0] d, v;
    logic [31:0] m_ccfg [NCH];
    logic [31:0] m_cmp  [NCH];
    logic [31:0] m_stp  [NCH];
    int ch, r;
    do_reset();
    for (int i = 0; i < int'(NCH); i++) begin
      m_ccfg[i] = 32'h0; m_cmp[i] = 32'hFFFF_FFFF; m_stp[i] = 32'h0;
    end
    for (int n = 0; n < 12; n++) begin
      ch = int'($urandom_range(0, NCH - 1));
      r  = int'($urandom_range(0, 2));
      v  = $urandom;
      apb_write(ch_addr(ch, 4 * r), v);
      if (r == 0) m_ccfg[ch] = v & 32'h3;
      else if (r == 1) m_cmp[ch] = v;
      else m_stp[ch] = v;
    end
    apb_write(8'h1C, 32'hDEAD_BEEF);
    apb_write(8'hF0, 32'hDEAD_BEEF);
    for (int i = 0; i < int'(NCH); i++) begin
      apb_read(ch_addr(i, 0), d); checks++; if (d !== m_ccfg[i]) begin errors++; $display("FAIL regs_ccfg%0d got %h exp %h", i, d, m_ccfg[i]); end
      apb_read(ch_addr(i, 4), d); checks++; if (d !== m_cmp[i]) begin errors++; $display("FAIL regs_cmp%0d got %h exp %h", i, d, m_cmp[i]); end
      apb_read(ch_addr(i, 8), d); checks++; if (d !== m_stp[i]) begin errors++; $display("FAIL regs_stp%0d got %h exp %h", i, d, m_stp[i]); end
    end
    apb_read(8'h1C, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL regs_unmapped_1c got %h exp 0", d); end
    apb_read(8'hF0, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL regs_unmapped_f0 got %h exp 0", d); end
    apb_write(8'h00, 32'hFFFF_FFFE);
    apb_read(8'h00, d); checks++; if (d !== 32'h2) begin errors++; $display("FAIL regs_gcfg got %h exp 2", d); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    int c, m;
    do_reset();
    c = int'($urandom_range(5, 30));
    apb_write(ch_addr(0, 4), 32'(c));
    apb_write(ch_addr(0, 0), 32'h1);
    apb_write(8'h00, 32'h1);
    // Tick k (count k-1 before increment) lands on the k-th edge after the start write
    checks++; if (int_vec !== '0) begin errors++; $display("FAIL oneshot_pre got %b exp 0", int_vec); end
    m = 0;
    while (int_vec[0] !== 1'b1 && m < 200) begin
      @(negedge apb_pclk);
      m++;
    end
    checks++; if (m !== c + 1) begin errors++; $display("FAIL oneshot_latency got %0d exp %0d", m, c + 1); end
    checks++; if (int_o !== 1'b1) begin errors++; $display("FAIL oneshot_int_o got %b exp 1", int_o); end
    apb_read(8'h04, d); checks++; if (d !== 32'(c + 3)) begin errors++; $display("FAIL oneshot_cnt got %0d exp %0d", d, c + 3); end
    apb_read(8'h08, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL oneshot_sts got %h exp 1", d); end
    apb_read(ch_addr(0, 4), d); checks++; if (d !== 32'(c)) begin errors++; $display("FAIL oneshot_cmp got %0d exp %0d", d, c); end
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    int c;
    do_reset();
    c = int'($urandom_range(10, 40));
    apb_write(ch_addr(0, 4), 32'(c));
    apb_write(ch_addr(0, 0), 32'h1);
    apb_write(8'h00, 32'h1);
    // Clear strobe lands on the same edge as the tick with count == c
    repeat (c - 2) @(negedge apb_pclk);
    apb_write(8'h08, 32'h1);
    checks++; if (int_vec[0] !== 1'b1) begin errors++; $display("FAIL race_int_vec got %b exp 1", int_vec[0]); end
    apb_read(8'h08, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL race_sts got %h exp 1", d); end
    apb_write(8'h08, 32'h1);
    apb_read(8'h08, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL race_clear got %h exp 0", d); end
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL race_int_o got %b exp 0", int_o); end
  endtask

  // Random one-shot/periodic programs on all channels, checked after a timed run
  task automatic test_periodic();
    logic [31:0] d;
    logic [31:0] c0 [NCH];
    logic [31:0] st [NCH];
    logic [31:0] cm;
    logic        per [NCH];
    logic        ie  [NCH];
    logic [NCH-1:0] exp_sts, exp_vec;
    int w, nt, pc;
    pc = (NCH > 1) ? 1 : 0;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int i = 0; i < int'(NCH); i++) begin
        c0[i]  = 32'($urandom_range(0, 30));
        st[i]  = 32'($urandom_range(0, 9));
        per[i] = 1'($urandom_range(0, 1));
        ie[i]  = 1'($urandom_range(0, 1));
      end
      if (it == 0) begin
        c0[pc] = 32'd5; st[pc] = 32'd7; per[pc] = 1'b1; ie[pc] = 1'b1;
      end
      for (int i = 0; i < int'(NCH); i++) begin
        apb_write(ch_addr(i, 4), c0[i]);
        apb_write(ch_addr(i, 8), st[i]);
        apb_write(ch_addr(i, 0), {30'h0, per[i], ie[i]});
      end
      w = (it == 0) ? int'($urandom_range(17, 23)) : int'($urandom_range(17, 40));
      apb_write(8'h00, 32'h1);
      repeat (w) @(negedge apb_pclk);
      apb_write(8'h00, 32'h0);
      // Counts 0 .. nt-1 were ticked
      nt = w + 3;
      apb_read(8'h04, d); checks++; if (d !== 32'(nt)) begin errors++; $display("FAIL per%0d_cnt got %0d exp %0d", it, d, nt); end
      exp_sts = '0;
      for (int i = 0; i < int'(NCH); i++) begin
        cm = c0[i];
        for (int k = 0; k < nt; k++) begin
          if (32'(k) == cm) begin
            exp_sts[i] = 1'b1;
            if (per[i]) cm = cm + st[i];
          end
        end
        apb_read(ch_addr(i, 4), d); checks++; if (d !== cm) begin errors++; $display("FAIL per%0d_cmp%0d got %0d exp %0d", it, i, d, cm); end
      end
      for (int i = 0; i < int'(NCH); i++) exp_vec[i] = exp_sts[i] & ie[i];
      apb_read(8'h08, d); checks++; if (d !== 32'(exp_sts)) begin errors++; $display("FAIL per%0d_sts got %h exp %h", it, d, exp_sts); end
      checks++; if (int_vec !== exp_vec) begin errors++; $display("FAIL per%0d_int_vec got %b exp %b", it, int_vec, exp_vec); end
      checks++; if (int_o !== (|exp_vec)) begin errors++; $display("FAIL per%0d_int_o got %b exp %b", it, int_o, |exp_vec); end
    end
  endtask

  task automatic test_run_lock();
    logic [31:0] d;
    do_reset();
    apb_write(8'h00, 32'h1);
    apb_write(ch_addr(0, 4), 32'h1234_5678);
    apb_write(ch_addr(0, 8), 32'h0000_ABCD);
    apb_write(8'h04, 32'h0000_0077);
    apb_write(ch_addr(0, 0), 32'h2);
    apb_write(8'h00, 32'h0);
    // Five writes of three cycles each while running: 15 ticks
    apb_read(8'h04, d); checks++; if (d !== 32'd15) begin errors++; $display("FAIL lock_cnt got %h exp 0000000f", d); end
    apb_read(ch_addr(0, 4), d); checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lock_cmp got %h exp ffffffff", d); end
    apb_read(ch_addr(0, 8), d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL lock_stp got %h exp 0", d); end
    apb_read(ch_addr(0, 0), d); checks++; if (d !== 32'h2) begin errors++; $display("FAIL lock_ccfg got %h exp 2", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    do_reset();
    apb_write(ch_addr(0, 4), 32'd3);
    apb_write(ch_addr(0, 0), 32'h1);
    apb_write(8'h00, 32'h3);
    repeat (10) @(negedge apb_pclk);
    checks++; if (int_o !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b exp 1", int_o); end
    #2 apb_prstn = 1'b0;
    #1;
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL midrst_int_o got %b exp 0", int_o); end
    checks++; if (int_vec !== '0) begin errors++; $display("FAIL midrst_int_vec got %b exp 0", int_vec); end
    @(negedge apb_pclk);
    apb_prstn = 1'b1;
    apb_read(8'h00, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_gcfg got %h exp 0", d); end
    apb_read(8'h04, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_cnt got %h exp 0", d); end
    apb_read(8'h08, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_sts got %h exp 0", d); end
    apb_read(ch_addr(0, 4), d); checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midrst_cmp got %h exp ffffffff", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d, all_sts;
    do_reset();
    all_sts = (32'd1 << (NCH + 1)) - 32'd1;
    apb_write(8'h04, 32'hFFFF_FFFE);
    apb_write(8'h00, 32'h3);
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL ovf_t0 got %b exp 0", int_o); end
    @(negedge apb_pclk);
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL ovf_t1 got %b exp 0", int_o); end
    @(negedge apb_pclk);
    checks++; if (int_o !== 1'b1) begin errors++; $display("FAIL ovf_t2 got %b exp 1", int_o); end
    checks++; if (int_vec !== '0) begin errors++; $display("FAIL ovf_int_vec got %b exp 0", int_vec); end
    apb_write(8'h04, 32'h0000_1234);
    // 0xFFFFFFFE plus seven ticks, the CNT write being dropped
    apb_read(8'h04, d); checks++; if (d !== 32'd5) begin errors++; $display("FAIL ovf_cnt got %h exp 5", d); end
    // Every CMP is still all-ones, so all channels matched on the wrap tick too
    apb_read(8'h08, d); checks++; if (d !== all_sts) begin errors++; $display("FAIL ovf_sts got %h exp %h", d, all_sts); end
    apb_write(8'h08, 32'd1 << NCH);
    apb_read(8'h08, d); checks++; if (d !== (all_sts >> 1)) begin errors++; $display("FAIL ovf_clear got %h exp %h", d, all_sts >> 1); end
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL ovf_int_o_clr got %b exp 0", int_o); end
  endtask

  task automatic test_prescaler();
    logic [31:0] d;
`ifdef HPET_PRESCALER_EN
    int w;
    do_reset();
    apb_write(8'h0C, 32'h3);
    apb_read(8'h0C, d); checks++; if (d !== 32'h3) begin errors++; $display("FAIL psc_rd got %h exp 3", d); end
    w = int'($urandom_range(10, 30));
    apb_write(8'h00, 32'h1);
    repeat (w) @(negedge apb_pclk);
    apb_write(8'h00, 32'h0);
    apb_read(8'h04, d); checks++; if (d !== 32'((w + 3) / 4)) begin errors++; $display("FAIL psc_cnt got %0d exp %0d", d, (w + 3) / 4); end
`else
    do_reset();
    apb_write(8'h0C, 32'h0000_00AB);
    apb_read(8'h0C, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL psc_off got %h exp 0", d); end
`endif
  endtask

  initial begin
    test_reset();
    test_regs();
    test_oneshot();
    test_w1c_race();
    test_periodic();
    test_run_lock();
    test_reset_mid();
    test_overflow();
    test_prescaler();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
